// File: rtl/rle_compressor.sv
// rle_compressor
//   Run-length compressor feeding index_scanner. Each new value is emitted
//   once; a second identical value is emitted again and followed by a count
//   of further repeats, written as 16'hffff continuation words and closed by
//   a terminator word below 16'hffff. Words are buffered in an output FIFO.
//
// Ports
//   clk            system clock
//   rst            asynchronous active-high reset
//   sample         raw 16-bit sample, qualified by sample_strobe
//   sample_strobe  one raw sample this cycle (no backpressure)
//   flush          end of capture, closes any open run
//   out_data       FIFO head word (0 when empty)
//   out_valid      FIFO not empty
//   out_ready      consumer accepts out_data when out_valid && out_ready
//   overflow       sticky flag: words were dropped; cleared only by rst
//   idle           FSM idle and FIFO empty
module rle_compressor #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] sample,
  input  logic        sample_strobe,
  input  logic        flush,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        idle
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_RUN
  } state_t;

  state_t        state, state_n;
  logic [15:0]   last, last_n;
  logic [15:0]   cnt, cnt_n;
  logic [1:0]    push_n;
  logic [15:0]   word0, word1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic [AW:0]   push_ext;
  logic [AW:0]   num_wr;
  logic          do_write;
  logic          drop;
  logic          pop;

  // Next-state logic. Strobe processing happens first; flush then acts on
  // the post-strobe state, so a run opened or extended this cycle is closed
  // with its updated count. Word order is word0 then word1.
  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    push_n  = 2'd0;
    word0   = 16'h0000;
    word1   = 16'h0000;

    if (sample_strobe) begin
      case (state)
        S_IDLE: begin
          word0   = sample;
          push_n  = 2'd1;
          last_n  = sample;
          state_n = S_SINGLE;
        end
        S_SINGLE: begin
          word0  = sample;
          push_n = 2'd1;
          if (sample == last) begin
            cnt_n   = 16'h0000;
            state_n = S_RUN;
          end else begin
            last_n = sample;
          end
        end
        S_RUN: begin
          if (sample == last) begin
            // Continuation word is emitted instead of letting cnt reach ffff,
            // so a terminator can never be confused with a continuation.
            if (cnt == 16'hfffe) begin
              word0  = 16'hffff;
              push_n = 2'd1;
              cnt_n  = 16'h0000;
            end else begin
              cnt_n = cnt + 16'd1;
            end
          end else begin
            word0   = cnt;
            word1   = sample;
            push_n  = 2'd2;
            last_n  = sample;
            state_n = S_SINGLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (flush) begin
      if (state_n == S_RUN) begin
        if (push_n == 2'd0) begin
          word0 = cnt_n;
        end else begin
          word1 = cnt_n;
        end
        push_n  = push_n + 2'd1;
        state_n = S_IDLE;
      end else if (state_n == S_SINGLE) begin
        state_n = S_IDLE;
      end
    end
  end

  // Space check uses the count registered at the start of the cycle; a
  // same-cycle pop does not make room. A cycle's words are written all or
  // nothing.
  always_comb begin
    free     = (AW+1)'(DEPTH) - count;
    push_ext = (AW+1)'(push_n);
    drop     = (push_n != 2'd0) && (free < push_ext);
    do_write = (push_n != 2'd0) && !drop;
    num_wr   = do_write ? push_ext : '0;
    pop      = out_valid && out_ready;
  end

  // FSM registers advance even when the cycle's words were dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      last  <= 16'h0000;
      cnt   <= 16'h0000;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + AW'(push_n);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + num_wr - (AW+1)'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= word0;
      if (push_n == 2'd2) begin
        mem[wr_ptr + AW'(1)] <= word1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 16'h0000;
  assign idle      = (state == S_IDLE) && (count == '0);

endmodule

// File: tb/tb_rle_compressor.sv
// tb_rle_compressor
//   Directed testbench for rle_compressor: reset state, distinct values,
//   short runs, long runs with continuation words, flush, FIFO overflow and
//   reset in the middle of a run.
module tb_rle_compressor;

  logic        clk;
  logic        rst;
  logic [15:0] sample;
  logic        sample_strobe;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        idle;

  int checks = 0;
  int errors = 0;

  logic [15:0] got [$];

  rle_compressor #(.DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .flush         (flush),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overflow      (overflow),
    .idle          (idle)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Collect every accepted word; sampled on the falling edge so that inputs
  // and outputs are stable.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(out_data);
    end
  end

  // One cycle of stimulus; inputs are applied just after a rising edge.
  task automatic applyStimulus(input logic [15:0] v, input logic st, input logic fl);
    sample        = v;
    sample_strobe = st;
    flush         = fl;
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    flush         = 1'b0;
  endtask

  // Wait until the FIFO has been emptied, with a cycle budget.
  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s drain timeout: out_valid still %0b, required 0", name, out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sample = 16'h0000;
    sample_strobe = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid got %0b expected 0", out_valid);
    end
    checks++;
    if (out_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data got %h expected 0000", out_data);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_overflow got %0b expected 0", overflow);
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle got %0b expected 1", idle);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_distinct;
    logic [15:0] exp [3];
    exp = '{16'h0001, 16'h0002, 16'h0003};
    got.delete();
    applyStimulus(16'h0001, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_latency out_valid got %0b expected 1", out_valid);
    end
    applyStimulus(16'h0002, 1'b1, 1'b0);
    applyStimulus(16'h0003, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    wait_drain("distinct");
    checks++;
    if (got.size() !== 3) begin
      errors++;
      $display("[TB] FAIL distinct_count got %0d expected 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL distinct_word%0d got %h expected %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL distinct_overflow got %0b expected 0", overflow);
    end
  endtask

  task automatic test_short_run;
    logic [15:0] exp [4];
    exp = '{16'h0005, 16'h0005, 16'h0002, 16'h0006};
    got.delete();
    repeat (4) applyStimulus(16'h0005, 1'b1, 1'b0);
    applyStimulus(16'h0006, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    wait_drain("short_run");
    checks++;
    if (got.size() !== 4) begin
      errors++;
      $display("[TB] FAIL short_run_count got %0d expected 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL short_run_word%0d got %h expected %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_long_run;
    logic [15:0] exp [5];
    exp = '{16'h0007, 16'h0007, 16'hffff, 16'h0000, 16'h0008};
    got.delete();
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(16'h0007, 1'b1, 1'b0);
    end
    applyStimulus(16'h0008, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    wait_drain("long_run");
    checks++;
    if (got.size() !== 5) begin
      errors++;
      $display("[TB] FAIL long_run_count got %0d expected 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL long_run_word%0d got %h expected %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      end
    end
  endtask

  task automatic test_flush;
    logic [15:0] exp [3];
    exp = '{16'h0009, 16'h0009, 16'h0000};
    got.delete();
    applyStimulus(16'h0009, 1'b1, 1'b0);
    applyStimulus(16'h0009, 1'b1, 1'b1);
    wait_drain("flush");
    checks++;
    if (got.size() !== 3) begin
      errors++;
      $display("[TB] FAIL flush_count got %0d expected 3", got.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++;
        $display("[TB] FAIL flush_word%0d got %h expected %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, exp[i]);
      end
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_idle got %0b expected 1", idle);
    end
  endtask

  task automatic test_overflow;
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(16'h0100 + 16'(i), 1'b1, 1'b0);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_full_no_drop got %0b expected 0", overflow);
    end
    applyStimulus(16'h0110, 1'b1, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_flag got %0b expected 1", overflow);
    end
    checks++;
    if (out_data !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL overflow_head got %h expected 0100", out_data);
    end
    applyStimulus(16'h0000, 1'b0, 1'b1);
    out_ready = 1'b1;
    wait_drain("overflow");
    checks++;
    if (got.size() !== 16) begin
      errors++;
      $display("[TB] FAIL overflow_count got %0d expected 16", got.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== 16'h0100 + 16'(i)) begin
        errors++;
        $display("[TB] FAIL overflow_word%0d got %h expected %h", i,
                 (i < got.size()) ? got[i] : 16'hxxxx, 16'h0100 + 16'(i));
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky got %0b expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1'b0;
    repeat (10) applyStimulus(16'h0004, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_prefill got %0b expected 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_async_valid got %0b expected 0", out_valid);
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_idle got %0b expected 1", idle);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrun_overflow_cleared got %0b expected 0", overflow);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    @(posedge clk);
    #1;
    applyStimulus(16'h0004, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    wait_drain("midrun");
    checks++;
    if (got.size() !== 1) begin
      errors++;
      $display("[TB] FAIL midrun_restart_count got %0d expected 1", got.size());
    end
    checks++;
    if (got.size() < 1 || got[0] !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL midrun_restart_word got %h expected 0004",
               (got.size() > 0) ? got[0] : 16'hxxxx);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_distinct();
    test_short_run();
    test_long_run();
    test_flush();
    test_overflow();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
